// File: rtl/wash_pkg.sv
// rtl/wash_pkg.sv - shared state encoding, default phase durations and phase ordering
//
// Purpose : common definitions for the wash sequencer.
// Contents: wash_state_e (3-bit state enum), default phase durations,
//           next_phase() helper giving the running-phase order.
package wash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_WASH  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_SPIN  = 3'd4,
    ST_DONE  = 3'd5,
    ST_PAUSE = 3'd6
  } wash_state_e;

  localparam int DEF_FILL_SEC  = 10;
  localparam int DEF_DRAIN_SEC = 8;
  localparam int DEF_SPIN_SEC  = 15;

  // Phase that follows a running phase once its countdown expires.
  function automatic wash_state_e next_phase(input wash_state_e s);
    case (s)
      ST_FILL:  next_phase = ST_WASH;
      ST_WASH:  next_phase = ST_DRAIN;
      ST_DRAIN: next_phase = ST_SPIN;
      default:  next_phase = ST_DONE;
    endcase
  endfunction

endpackage

// File: rtl/phase_countdown.sv
// rtl/phase_countdown.sv - loadable down-counter holding the seconds left in a phase
//
// Purpose : 7-bit countdown; load wins over everything, otherwise decrement on
//           tick_en unless hold is set, saturating at zero.
// Ports   : clk, rst_n (async active-low)
//           load, load_val[W-1:0]  - synchronous load
//           tick_en                - decrement request
//           hold                   - freeze the count
//           count[W-1:0]           - registered count
//           zero                   - count == 0
module phase_countdown #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick_en,
  input  logic         hold,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (tick_en && !hold && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/wash_sequencer.sv
// rtl/wash_sequencer.sv - washing-machine cycle sequencer FILL/WASH/DRAIN/SPIN with pause
//
// Purpose : steps through the wash cycle on 1 Hz ticks, drives actuator enables,
//           supports pause/resume and an optional door interlock.
// Config  : define WASH_DOOR_LOCK_EN to enable the door interlock.
// Ports   : clk, rst (async active-low), tick_1hz, start, pause, settimer[6:0],
//           door_closed -> valve_on, motor_on, drain_on, spin_on, phase[2:0],
//           remain[6:0], done, door_lock. All outputs come straight from flops.
module wash_sequencer
  import wash_pkg::*;
#(
  parameter int FILL_SEC  = DEF_FILL_SEC,
  parameter int DRAIN_SEC = DEF_DRAIN_SEC,
  parameter int SPIN_SEC  = DEF_SPIN_SEC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       start,
  input  logic       pause,
  input  logic [6:0] settimer,
  input  logic       door_closed,
  output logic       valve_on,
  output logic       motor_on,
  output logic       drain_on,
  output logic       spin_on,
  output logic [2:0] phase,
  output logic [6:0] remain,
  output logic       done,
  output logic       door_lock
);

  localparam logic [6:0] FILL_LEN  = 7'(FILL_SEC);
  localparam logic [6:0] DRAIN_LEN = 7'(DRAIN_SEC);
  localparam logic [6:0] SPIN_LEN  = 7'(SPIN_SEC);

  wash_state_e state_q, state_d;
  wash_state_e saved_q, saved_d;
  logic [6:0]  wash_len_q, wash_len_d;
  logic        valve_q, valve_d;
  logic        motor_q, motor_d;
  logic        drain_q, drain_d;
  logic        spin_q, spin_d;
  logic        done_q, done_d;
  logic        door_lock_q, door_lock_d;

  logic        cnt_load;
  logic [6:0]  cnt_load_val;
  logic        cnt_tick;
  logic        cnt_hold;
  logic        cnt_zero;
  logic [6:0]  cnt_value;
  logic        door_ok;

`ifdef WASH_DOOR_LOCK_EN
  assign door_ok = door_closed;
`else
  logic unused_door_closed;
  assign unused_door_closed = door_closed;
  assign door_ok = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    saved_d      = saved_q;
    wash_len_d   = wash_len_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_tick     = 1'b0;
    cnt_hold     = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start && door_ok) begin
          wash_len_d   = settimer;
          state_d      = ST_FILL;
          cnt_load     = 1'b1;
          cnt_load_val = FILL_LEN;
        end
      end
      ST_FILL, ST_WASH, ST_DRAIN, ST_SPIN: begin
        // Pause (or an opened door) outranks a same-cycle tick, which is dropped.
        if (pause || !door_ok) begin
          state_d  = ST_PAUSE;
          saved_d  = state_q;
          cnt_hold = 1'b1;
        end else if (cnt_zero || (tick_1hz && (cnt_value == 7'd1))) begin
          // A zero-length phase is left on the next clock without a tick.
          state_d  = next_phase(state_q);
          cnt_load = 1'b1;
          case (next_phase(state_q))
            ST_WASH:  cnt_load_val = wash_len_q;
            ST_DRAIN: cnt_load_val = DRAIN_LEN;
            ST_SPIN:  cnt_load_val = SPIN_LEN;
            default:  cnt_load_val = '0;
          endcase
        end else begin
          cnt_tick = tick_1hz;
        end
      end
      ST_PAUSE: begin
        cnt_hold = 1'b1;
        if (pause && door_ok) begin
          state_d = saved_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output flops are loaded from the next state so they line up with state_q.
  always_comb begin
    valve_d = (state_d == ST_FILL);
    motor_d = (state_d == ST_WASH);
    drain_d = (state_d == ST_DRAIN) || (state_d == ST_SPIN);
    spin_d  = (state_d == ST_SPIN);
    done_d  = (state_d == ST_DONE);
`ifdef WASH_DOOR_LOCK_EN
    door_lock_d = (state_d == ST_FILL) || (state_d == ST_WASH) || (state_d == ST_DRAIN) ||
                  (state_d == ST_SPIN) || (state_d == ST_PAUSE);
`else
    door_lock_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      saved_q     <= ST_IDLE;
      wash_len_q  <= '0;
      valve_q     <= 1'b0;
      motor_q     <= 1'b0;
      drain_q     <= 1'b0;
      spin_q      <= 1'b0;
      done_q      <= 1'b0;
      door_lock_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      saved_q     <= saved_d;
      wash_len_q  <= wash_len_d;
      valve_q     <= valve_d;
      motor_q     <= motor_d;
      drain_q     <= drain_d;
      spin_q      <= spin_d;
      done_q      <= done_d;
      door_lock_q <= door_lock_d;
    end
  end

  phase_countdown #(.W(7)) u_countdown (
    .clk      (clk),
    .rst_n    (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .tick_en  (cnt_tick),
    .hold     (cnt_hold),
    .count    (cnt_value),
    .zero     (cnt_zero)
  );

  assign phase     = state_q;
  assign remain    = cnt_value;
  assign valve_on  = valve_q;
  assign motor_on  = motor_q;
  assign drain_on  = drain_q;
  assign spin_on   = spin_q;
  assign done      = done_q;
  assign door_lock = door_lock_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// tb/tb_wash_sequencer.sv - directed self-checking bench for wash_sequencer
module tb_wash_sequencer;

  localparam logic [2:0] P_IDLE  = 3'd0;
  localparam logic [2:0] P_FILL  = 3'd1;
  localparam logic [2:0] P_WASH  = 3'd2;
  localparam logic [2:0] P_DRAIN = 3'd3;
  localparam logic [2:0] P_SPIN  = 3'd4;
  localparam logic [2:0] P_DONE  = 3'd5;
  localparam logic [2:0] P_PAUSE = 3'd6;

  // Actuator patterns {valve, motor, drain, spin}
  localparam logic [3:0] A_NONE  = 4'b0000;
  localparam logic [3:0] A_FILL  = 4'b1000;
  localparam logic [3:0] A_WASH  = 4'b0100;
  localparam logic [3:0] A_DRAIN = 4'b0010;
  localparam logic [3:0] A_SPIN  = 4'b0011;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [6:0] settimer = 7'd0;
  logic       door_closed = 1'b1;
  logic       valve_on, motor_on, drain_on, spin_on, done, door_lock;
  logic [2:0] phase;
  logic [6:0] remain;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wash_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .tick_1hz    (tick_1hz),
    .start       (start),
    .pause       (pause),
    .settimer    (settimer),
    .door_closed (door_closed),
    .valve_on    (valve_on),
    .motor_on    (motor_on),
    .drain_on    (drain_on),
    .spin_on     (spin_on),
    .phase       (phase),
    .remain      (remain),
    .done        (done),
    .door_lock   (door_lock)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    tick_1hz = 1'b1;
    cyc();
    tick_1hz = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic pulse_pause();
    pause = 1'b1;
    cyc();
    pause = 1'b0;
  endtask

  // Compares {phase, remain, actuators, done, door_lock} against hand values.
  task automatic chk(input string tag, input logic [2:0] ph, input logic [6:0] rem,
                     input logic [3:0] act, input logic lock_exp);
    logic [15:0] obs;
    logic [15:0] exp_v;
    obs   = {phase, remain, valve_on, motor_on, drain_on, spin_on, done, door_lock};
    exp_v = {ph, rem, act, (ph == P_DONE), lock_exp};
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

`ifdef WASH_DOOR_LOCK_EN
  localparam logic LK = 1'b1;
`else
  localparam logic LK = 1'b0;
`endif

  task automatic run_ticks(input string tag, input logic [2:0] ph, input int from,
                           input int n, input logic [3:0] act, input logic lk);
    for (int i = 1; i <= n; i++) begin
      pulse_tick();
      chk(tag, ph, 7'(from - i), act, lk);
    end
  endtask

  initial begin
    // Reset state
    #12;
    chk("reset", P_IDLE, 7'd0, A_NONE, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    cyc();
    chk("idle_after_reset", P_IDLE, 7'd0, A_NONE, 1'b0);

    // Full cycle with settimer=5, settimer change after start ignored
    settimer = 7'd5;
    pulse_start();
    settimer = 7'd9;
    chk("fill_entry", P_FILL, 7'd10, A_FILL, LK);
    cyc();
    chk("fill_hold_no_tick", P_FILL, 7'd10, A_FILL, LK);
    run_ticks("fill_count", P_FILL, 10, 9, A_FILL, LK);
    pulse_tick();
    chk("wash_entry", P_WASH, 7'd5, A_WASH, LK);
    pulse_start();
    chk("start_ignored_wash", P_WASH, 7'd5, A_WASH, LK);
    run_ticks("wash_count", P_WASH, 5, 4, A_WASH, LK);
    pulse_tick();
    chk("drain_entry", P_DRAIN, 7'd8, A_DRAIN, LK);
    run_ticks("drain_count", P_DRAIN, 8, 7, A_DRAIN, LK);
    pulse_tick();
    chk("spin_entry", P_SPIN, 7'd15, A_SPIN, LK);
    run_ticks("spin_count", P_SPIN, 15, 14, A_SPIN, LK);
    pulse_tick();
    chk("done_entry", P_DONE, 7'd0, A_NONE, 1'b0);
    pulse_pause();
    chk("pause_ignored_done", P_DONE, 7'd0, A_NONE, 1'b0);

    // Zero wash length: WASH lasts one clock, DRAIN without a tick
    settimer = 7'd0;
    pulse_start();
    settimer = 7'd3;
    chk("restart_from_done", P_FILL, 7'd10, A_FILL, LK);
    run_ticks("fill2_count", P_FILL, 10, 9, A_FILL, LK);
    pulse_tick();
    chk("wash_zero", P_WASH, 7'd0, A_WASH, LK);
    cyc();
    chk("wash_skip_drain", P_DRAIN, 7'd8, A_DRAIN, LK);
    run_ticks("drain2_count", P_DRAIN, 8, 7, A_DRAIN, LK);
    pulse_tick();
    chk("spin2_entry", P_SPIN, 7'd15, A_SPIN, LK);
    run_ticks("spin2_count", P_SPIN, 15, 3, A_SPIN, LK);

    // Asynchronous reset in SPIN
    rst = 1'b0;
    #2;
    chk("async_reset_spin", P_IDLE, 7'd0, A_NONE, 1'b0);
    cyc();
    rst = 1'b1;
    cyc();
    chk("idle_after_abort", P_IDLE, 7'd0, A_NONE, 1'b0);
    pulse_pause();
    chk("pause_ignored_idle", P_IDLE, 7'd0, A_NONE, 1'b0);
    pulse_tick();
    chk("tick_ignored_idle", P_IDLE, 7'd0, A_NONE, 1'b0);

    // Pause in WASH at remain=3
    settimer = 7'd5;
    pulse_start();
    run_ticks("fill3_count", P_FILL, 10, 9, A_FILL, LK);
    pulse_tick();
    chk("wash3_entry", P_WASH, 7'd5, A_WASH, LK);
    run_ticks("wash3_count", P_WASH, 5, 2, A_WASH, LK);
    pulse_pause();
    chk("pause_enter", P_PAUSE, 7'd3, A_NONE, LK);
    for (int i = 0; i < 4; i++) begin
      pulse_tick();
      chk("pause_frozen", P_PAUSE, 7'd3, A_NONE, LK);
    end
    pulse_pause();
    chk("resume_wash", P_WASH, 7'd3, A_WASH, LK);
    run_ticks("wash3_resume", P_WASH, 3, 2, A_WASH, LK);
    pulse_tick();
    chk("drain3_entry", P_DRAIN, 7'd8, A_DRAIN, LK);
    run_ticks("drain3_count", P_DRAIN, 8, 7, A_DRAIN, LK);

    // Pause and tick together at remain=1 in DRAIN
    pause = 1'b1;
    tick_1hz = 1'b1;
    cyc();
    pause = 1'b0;
    tick_1hz = 1'b0;
    chk("pause_beats_tick", P_PAUSE, 7'd1, A_NONE, LK);
    pulse_tick();
    chk("pause_no_spin", P_PAUSE, 7'd1, A_NONE, LK);
    pulse_pause();
    chk("resume_drain", P_DRAIN, 7'd1, A_DRAIN, LK);
    pulse_tick();
    chk("spin3_entry", P_SPIN, 7'd15, A_SPIN, LK);

    rst = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();

`ifdef WASH_DOOR_LOCK_EN
    door_closed = 1'b0;
    pulse_start();
    chk("door_open_start", P_IDLE, 7'd0, A_NONE, 1'b0);
    door_closed = 1'b1;
    pulse_start();
    chk("door_fill", P_FILL, 7'd10, A_FILL, 1'b1);
    pulse_tick();
    chk("door_fill_tick", P_FILL, 7'd9, A_FILL, 1'b1);
    door_closed = 1'b0;
    cyc();
    chk("door_force_pause", P_PAUSE, 7'd9, A_NONE, 1'b1);
    pulse_pause();
    chk("door_resume_refused", P_PAUSE, 7'd9, A_NONE, 1'b1);
    door_closed = 1'b1;
    cyc();
    chk("door_closed_still_paused", P_PAUSE, 7'd9, A_NONE, 1'b1);
    pulse_pause();
    chk("door_resume_fill", P_FILL, 7'd9, A_FILL, 1'b1);
`else
    door_closed = 1'b0;
    pulse_start();
    chk("door_ignored_start", P_FILL, 7'd10, A_FILL, 1'b0);
    cyc();
    chk("door_ignored_run", P_FILL, 7'd10, A_FILL, 1'b0);
    door_closed = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wash_sequencer.md
WASH_SEQUENCER -- requirements
Module: wash_sequencer

Interface
REQ-001 SHALL have parameter FILL_SEC, default 10, fill-phase duration in seconds.
REQ-002 SHALL have parameter DRAIN_SEC, default 8, drain-phase duration in seconds.
REQ-003 SHALL have parameter SPIN_SEC, default 15, spin-phase duration in seconds.
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port tick_1hz  input  1  one-clk-wide pulse, once per second, synchronous to clk.
REQ-007 SHALL have port start  input  1  one-clk pulse, begin cycle.
REQ-008 SHALL have port pause  input  1  one-clk pulse, toggle pause/resume.
REQ-009 SHALL have port settimer  input  7  wash duration in seconds from the timer-setting block.
REQ-010 SHALL have port door_closed  input  1  door switch, 1 = closed.
REQ-011 SHALL have ports valve_on, motor_on, drain_on, spin_on  output  1 each  actuator enables.
REQ-012 SHALL have port phase  output  3  current state encoding.
REQ-013 SHALL have port remain  output  7  seconds left in current phase.
REQ-014 SHALL have port done  output  1  high while in DONE.
REQ-015 SHALL have port door_lock  output  1  door interlock latch.

Function
REQ-016 SHALL implement states IDLE, FILL, WASH, DRAIN, SPIN, DONE, PAUSE.
REQ-017 SHALL register settimer into wash_len on the clk edge that accepts start in IDLE or DONE; later settimer changes have no effect until the next start.
REQ-018 SHALL go IDLE/DONE -> FILL on start, loading remain = FILL_SEC.
REQ-019 SHALL decrement remain by 1 on each tick_1hz in a running phase.
REQ-020 SHALL, on tick_1hz with remain == 1, advance FILL->WASH->DRAIN->SPIN->DONE in that edge, loading the next phase duration (wash_len, DRAIN_SEC, SPIN_SEC, 0 for DONE).
REQ-021 SHALL skip a phase whose loaded duration is 0 on the following clk without waiting for a tick.
REQ-022 SHALL drive valve_on in FILL only, motor_on in WASH only, drain_on in DRAIN and SPIN, spin_on in SPIN only; all actuators 0 in IDLE, DONE, PAUSE.
REQ-023 SHALL, on pause in FILL/WASH/DRAIN/SPIN, enter PAUSE, save the phase, and freeze remain.
REQ-024 SHALL, on pause in PAUSE, return to the saved phase with remain unchanged.
REQ-025 SHALL ignore pause in IDLE and DONE, and ignore start outside IDLE and DONE.
REQ-026 SHALL give pause priority over tick_1hz in the same cycle; the tick is discarded.
REQ-027 SHALL register all outputs: state change visible one clk after the triggering edge, with no combinational input-to-output path.

Reset
REQ-028 SHALL, on rst low, force IDLE, remain=0, wash_len=0, saved phase=IDLE, and all outputs 0, immediately and regardless of clk.
REQ-029 SHALL, when reset occurs mid-cycle, abandon the cycle; after release it waits in IDLE for start.

Configuration
REQ-030 SHALL, with WASH_DOOR_LOCK_EN defined, hold door_lock=1 in FILL through SPIN and PAUSE, refuse start while door_closed=0, and force PAUSE from a running phase when door_closed=0; resume additionally requires door_closed=1.
REQ-031 SHALL, without WASH_DOOR_LOCK_EN, tie door_lock=0 and ignore door_closed.

Structure
REQ-032 SHALL take the state enum (3-bit) and default phase durations from shared package wash_pkg.
REQ-033 SHALL instantiate sub-module phase_countdown (7-bit loadable down-counter with tick enable, hold, and zero flag) for remain.

Verification
REQ-034 SHALL cover: settimer=5, start -> FILL 10 ticks, WASH 5, DRAIN 8, SPIN 15, then done=1 with correct actuator per phase.
REQ-035 SHALL cover: settimer=0, start -> after FILL, WASH lasts one clk, DRAIN entered without a tick.
REQ-036 SHALL cover: pause in WASH at remain=3, 4 ticks, pause -> remain still 3, motor_on back 1 clk later.
REQ-037 SHALL cover: pause and tick_1hz in the same cycle at remain=1 in DRAIN -> PAUSE, remain=1, no SPIN.
REQ-038 SHALL cover: rst low during SPIN -> IDLE, all outputs 0 asynchronously; settimer change after start ignored.
REQ-039 SHALL cover: with WASH_DOOR_LOCK_EN, door_closed=0 during FILL -> PAUSE, valve_on=0, door_lock=1; start with door open -> stays IDLE.
